// File: rtl/shift_word_feeder.sv
// Serialises valid/ready words MSB-first into a 1- or 2-bit-per-beat shift control stream.
// Beat 1 follows the transfer edge; in_ready only opens in IDLE or on the last beat, so the next word chains without a bubble.
module shift_word_feeder #(
  parameter int WORD_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              abort,
  output logic              shift_en,
  output logic              pair_en,
  output logic [WORD_W-1:0] shift_data,
  output logic              busy,
  output logic              word_done,
  output logic [CNT_W-1:0]  words_done
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] BEATS_PAIR = BW'(WORD_W / 2);
  localparam logic [BW-1:0] BEATS_ONE  = BW'(WORD_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] hold_q;
  logic              mode_q;
  logic [BW-1:0]     beats_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              last_beat;
  logic              xfer;
  logic              finish;
  logic [WORD_W-1:0] hold_d;
  logic [BW-1:0]     beats_d;
  logic [CNT_W-1:0]  cnt_d;

  assign last_beat = (state_q == SHIFT) && (beats_q == BW'(1));
  // abort closes the door even in IDLE, so a word never lands in an aborting cycle
  assign in_ready  = !abort && ((state_q == IDLE) || last_beat);
  assign xfer      = in_valid && in_ready;
  assign finish    = last_beat && !abort;
  assign hold_d    = mode_q ? (hold_q << 2) : (hold_q << 1);
  assign beats_d   = beats_q - BW'(1);
  assign cnt_d     = finish ? cnt_q + CNT_W'(1) : cnt_q;

  assign shift_en   = (state_q == SHIFT);
  assign pair_en    = shift_en && mode_q;
  assign busy       = shift_en;
  assign word_done  = finish;
  assign words_done = cnt_q;

  always_comb begin
    shift_data = '0;
    if (state_q == SHIFT) begin
      if (mode_q) shift_data[1:0] = hold_q[WORD_W-1 -: 2];
      else        shift_data[0]   = hold_q[WORD_W-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            hold_q  <= in_data;
            mode_q  <= in_mode;
            beats_q <= in_mode ? BEATS_PAIR : BEATS_ONE;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (xfer) begin
            hold_q  <= in_data;
            mode_q  <= in_mode;
            beats_q <= in_mode ? BEATS_PAIR : BEATS_ONE;
          end else if (last_beat) begin
            state_q <= IDLE;
          end else begin
            hold_q  <= hold_d;
            beats_q <= beats_d;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/shift_word_feeder.md
Name: shift_word_feeder

Overview:
- Upstream stage of the 6-bit shift register.
- Accepts whole parallel words over a valid/ready handshake.
- Serialises each word MSB-first into the shift register's shiftEnable / enable / dataIn controls, either 1 bit per beat or 2 bits per beat.
- After one complete word, with no intervening shifts, the downstream register holds exactly that word.

Parameters:
- WORD_W, 6, width of the accepted word and of shift_data; must be even and >= 2.
- CNT_W, 8, width of the words_done counter.

Ports:
- clk  input  1  Clock; all state updates on its rising edge.
- reset  input  1  Asynchronous, active-low reset (low = reset asserted).
- in_valid  input  1  Upstream word valid.
- in_ready  output  1  Feeder can accept a word this cycle.
- in_data  input  WORD_W  Word to serialise.
- in_mode  input  1  Sampled with the word: 1 = 2 bits/beat (pair mode), 0 = 1 bit/beat.
- abort  input  1  Synchronous: drop the word in flight.
- shift_en  output  1  Drives downstream shiftEnable.
- pair_en  output  1  Drives downstream enable (2-bit shift).
- shift_data  output  WORD_W  Drives downstream dataIn. Chunk in [1:0] (pair) or [0] (single); all other bits are 0.
- busy  output  1  A word is in flight.
- word_done  output  1  One-cycle pulse, coincident with the last beat of a word.
- words_done  output  CNT_W  Count of completed (non-aborted) words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, async) values:
  - State = IDLE.
  - in_ready=1, shift_en=0, pair_en=0, shift_data=0, busy=0, word_done=0, words_done=0.
  - Holding register and beat counter cleared.
- Reset mid-word discards the word. Downstream sees no further beats.
- States:
  - IDLE: no beats; in_ready=1.
  - SHIFT: one beat every cycle, no gaps.
- Transfer occurs on a rising edge where in_valid && in_ready.
  - At that edge: latch in_data into the holding register, latch in_mode into a mode flag, load beat count, go to SHIFT.
  - in_data and in_mode are ignored at all other times.
- Beats per word: WORD_W/2 in pair mode, WORD_W in single mode.
- Beat timing: transfer at edge k → beat 1 visible in cycle k+1 (after edge k) → last beat in cycle k+N.
- During SHIFT, every cycle:
  - shift_en=1; pair_en = mode flag; busy=1.
  - Pair mode: shift_data[1:0] = top 2 bits of the holding register.
  - Single mode: shift_data[0] = top bit.
  - At each edge the holding register shifts left by 2 (pair) or 1 (single).
- Order: MSB-first. For WORD_W=6, pair mode sends [5:4], then [3:2], then [1:0].
- Outputs are a function of registered state only; no combinational path from in_valid or in_data to the shift_* outputs.
- in_ready is 1 in IDLE, and in SHIFT during the last beat only.
  - A transfer on the last-beat edge reloads and continues with zero bubbles: beat 1 of the new word follows immediately.
  - Otherwise the feeder returns to IDLE and shift_en=0 the next cycle.
- word_done=1 during the last-beat cycle. words_done increments at the edge ending that cycle. 2^CNT_W−1 wraps to 0.
- abort:
  - Sampled at an edge while in SHIFT: go to IDLE. The remaining beats are never issued; no word_done; no counter increment.
  - in_ready is forced 0 during any cycle in which abort=1.
  - abort in IDLE has no effect except blocking the transfer that cycle.
- Simultaneous abort with the last beat: the abort wins. That beat is still visible during its cycle, but word_done is suppressed (forced 0 whenever abort=1) and no increment occurs.
- in_valid held high with in_ready low: no transfer, no state change. Upstream must hold in_data stable.

Test Plan:
- Reset, then in_data=6'b101101, in_mode=1, one transfer → 3 beats, shift_data[1:0] = 10, 11, 01; pair_en=1; word_done in beat 3; words_done=1; downstream register reads 6'b101101.
- in_data=6'b110010, in_mode=0 → 6 beats, shift_data[0] = 1,1,0,0,1,0; pair_en=0; shift_data[5:1]=0 throughout; in_ready low until beat 6.
- Back-to-back transfers 6'h2A (pair), then 6'h15 (single), in_valid held high → 9 consecutive shift_en cycles with no gap; words_done=2.
- abort asserted in beat 2 of a pair-mode word → IDLE next cycle, shift_en=0, words_done unchanged, no word_done; next transfer proceeds normally.
- reset driven low asynchronously mid-beat (between edges) → all outputs return to reset values immediately; after release, a new word serialises correctly from beat 1.
- CNT_W=2, 5 completed words → words_done sequence 1, 2, 3, 0, 1.
